// File: rtl/pb_io_pkg.sv
// Shared definitions for KCPSM6 port-mapped peripherals: register offsets,
// status bit positions and the UART transmitter state encoding.
package pb_io_pkg;

    localparam int DATA_OFS   = 0;
    localparam int STATUS_OFS = 1;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/picoblaze_uart_tx_if.sv
// KCPSM6 I/O bus as seen by a port-mapped peripheral.
interface picoblaze_uart_tx_if;

    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       WRITE_STROBE;
    logic       READ_STROBE;
    logic [7:0] IN_PORT;

    modport master (
        output PORT_ID, OUT_PORT, WRITE_STROBE, READ_STROBE,
        input  IN_PORT
    );

    modport slave (
        input  PORT_ID, OUT_PORT, WRITE_STROBE, READ_STROBE,
        output IN_PORT
    );

endinterface

// File: rtl/pb_sync_fifo.sv
// Single-clock FIFO with show-ahead output; extra pointer MSB separates
// full from empty. Push when full and pop when empty are ignored.
module pb_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-2:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/picoblaze_uart_tx.sv
// Port-mapped 8N1 UART transmitter for the KCPSM6 bus: byte FIFO, fixed-rate
// serialiser and a pollable status register.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | line high, waiting for the FIFO to hold a byte
//   S_START | start bit (line low) for one bit period
//   S_DATA  | eight data bits, LSB first, one bit period each
//   S_STOP  | stop bit (line high); chains straight into the next frame
module picoblaze_uart_tx
    import pb_io_pkg::*;
#(
    parameter int         CLKS_PER_BIT    = 868,
    parameter int         FIFO_DEPTH_LOG2 = 4,
    parameter logic [7:0] BASE_ADDR       = 8'h10
) (
    input  logic                      CLK_IN,
    input  logic                      RESET_IN,
    picoblaze_uart_tx_if.slave        bus,
    output logic                      TX_OUT,
    output logic                      IRQ_OUT
);

    localparam int               BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        DATA_ADDR   = BASE_ADDR + 8'(DATA_OFS);
    localparam logic [7:0]        STATUS_ADDR = BASE_ADDR + 8'(STATUS_OFS);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic [7:0]        shift_q;
    logic [7:0]        shift_nxt;
    logic              tx_q;
    logic              tx_nxt;
    logic              ovf_q;
    logic              irq_q;
    logic [7:0]        in_port_q;
    logic [7:0]        status;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;

    logic              wr_data;
    logic              rd_status;
    logic              overflow;
    logic              busy;
    logic              baud_tc;

    assign wr_data   = bus.WRITE_STROBE && (bus.PORT_ID == DATA_ADDR);
    assign rd_status = bus.READ_STROBE && (bus.PORT_ID == STATUS_ADDR);
    // Drop decision uses the registered full flag, so a pop on the same edge never makes room.
    assign fifo_push = wr_data && !fifo_full;
    assign overflow  = wr_data && fifo_full;
    assign busy      = (state != S_IDLE);
    assign baud_tc   = (baud_cnt == '0);

    pb_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (CLK_IN),
        .rst_n (RESET_IN),
        .push  (fifo_push),
        .din   (bus.OUT_PORT),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status           = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = ovf_q;
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_q;
        fifo_pop  = 1'b0;
        tx_nxt    = 1'b1;

        if (state != S_IDLE) begin
            baud_nxt = baud_tc ? BAUD_RELOAD : baud_cnt - BAUD_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dout;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    shift_nxt = {1'b0, shift_q[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dout;
                        state_nxt = S_START;
                    end else begin
                        baud_nxt  = '0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Line level is registered from the next state so it changes cleanly with the FSM.
        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            in_port_q <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            shift_q   <= shift_nxt;
            tx_q      <= tx_nxt;
            irq_q     <= fifo_empty && !busy;
            in_port_q <= (bus.PORT_ID == STATUS_ADDR) ? status : 8'h00;
            if (overflow) begin
                ovf_q <= 1'b1;
            end else if (rd_status) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign TX_OUT      = tx_q;
    assign IRQ_OUT     = irq_q;
    assign bus.IN_PORT = in_port_q;

endmodule
